// File: rtl/bb_game_feeder.sv
// bb_game_feeder: buffers one game of plays tagged with inning/half, then replays it as a gap-free burst.
// Define BB_FEEDER_TIMEOUT_EN to leave WAIT_DONE with an err pulse after TIMEOUT_CYC cycles without done_i.
module bb_game_feeder #(
  parameter int DEPTH = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [2:0] s_action,
  input  logic       s_last,
  output logic       bb_in_valid,
  output logic [1:0] bb_inning,
  output logic       bb_half,
  output logic [2:0] bb_action,
  input  logic       done_i,
  output logic       err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {LOAD, PLAY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [5:0] mem [DEPTH];
  logic [AW:0] cnt;
  logic [AW-1:0] rd;
  logic [1:0] inning, outs, add;
  logic [2:0] sum;
  logic half, fb, acc, ovf, wr_en, close, half_end, pop, tmo;
  always_comb begin
    acc = s_valid & s_ready;
    ovf = acc & (cnt == (AW+1)'(DEPTH));
    wr_en = acc & ~ovf;
    add = (s_action == 3'd5 || s_action == 3'd7) ? 2'd1 : s_action == 3'd6 ? (fb ? 2'd2 : 2'd1) : 2'd0;
    sum = {1'b0, outs} + {1'b0, add};
    half_end = sum >= 3'd3;
    close = wr_en & (s_last | (half_end & half & (inning == 2'd3)));
    pop = (state == PLAY) & (cnt != '0);
    state_nx = state;
    case (state)
      LOAD:      state_nx = close ? PLAY : LOAD;
      PLAY:      state_nx = pop ? PLAY : WAIT_DONE;
      WAIT_DONE: state_nx = (done_i | tmo) ? LOAD : WAIT_DONE;
      default:   state_nx = LOAD;
    endcase
  end
`ifdef BB_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  assign tmo = (state == WAIT_DONE) & ~done_i & (tcnt == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) tcnt <= (rst || state != WAIT_DONE) ? '0 : tcnt + 1'b1;
`else
  logic unused_tmo;
  assign tmo = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt[AW-1:0]] <= {inning, half, s_action};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      s_ready <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      rd <= '0;
      bb_in_valid <= 1'b0;
      {bb_inning, bb_half, bb_action} <= '0;
      inning <= 2'd1;
      half <= 1'b0;
      outs <= '0;
      fb <= 1'b0;
    end else begin
      state <= state_nx;
      s_ready <= state_nx == LOAD;
      err <= ovf | tmo;
      bb_in_valid <= pop;
      {bb_inning, bb_half, bb_action} <= pop ? mem[rd] : '0;
      cnt <= ovf ? '0 : wr_en ? cnt + 1'b1 : pop ? cnt - 1'b1 : cnt;
      rd <= pop ? rd + 1'b1 : '0;
      // tracking is held at the top of the 1st whenever a game is not being loaded
      if (ovf || close || state != LOAD) begin
        inning <= 2'd1;
        half <= 1'b0;
        outs <= '0;
        fb <= 1'b0;
      end else if (wr_en) begin
        if (half_end) begin
          outs <= '0;
          fb <= 1'b0;
          half <= ~half;
          inning <= inning + {1'b0, half};
        end else begin
          outs <= sum[1:0];
          fb <= s_action <= 3'd1 ? 1'b1 : s_action == 3'd7 ? fb : 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_bb_game_feeder.sv
// tb_bb_game_feeder: directed games with a scoreboard of expected burst tags per DUT.
module tb_bb_game_feeder;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic s_valid = 0, s_last = 0, done_i = 0;
  logic [2:0] s_action = 0;
  logic s_ready, bb_in_valid, bb_half, err;
  logic [1:0] bb_inning;
  logic [2:0] bb_action;
  logic s_valid2 = 0, s_last2 = 0, done_i2 = 0;
  logic [2:0] s_action2 = 0;
  logic s_ready2, bb_in_valid2, bb_half2, err2;
  logic [1:0] bb_inning2;
  logic [2:0] bb_action2;
  int n_vec = 0, n_err = 0;
  bit err_allow = 0;
  logic [5:0] q[$], q2[$];

  bb_game_feeder #(.DEPTH(64), .TIMEOUT_CYC(8)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_action(s_action),
    .s_last(s_last), .bb_in_valid(bb_in_valid), .bb_inning(bb_inning), .bb_half(bb_half),
    .bb_action(bb_action), .done_i(done_i), .err(err));

  bb_game_feeder #(.DEPTH(4), .TIMEOUT_CYC(8)) u_small (
    .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2), .s_action(s_action2),
    .s_last(s_last2), .bb_in_valid(bb_in_valid2), .bb_inning(bb_inning2), .bb_half(bb_half2),
    .bb_action(bb_action2), .done_i(done_i2), .err(err2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? s_ready2 : s_ready;
  endfunction
  function automatic logic vld(input bit sel);
    return sel ? bb_in_valid2 : bb_in_valid;
  endfunction

  always @(negedge clk) begin
    if (!rst && bb_in_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL burst tag: unexpected beat %0h, required none", {bb_inning, bb_half, bb_action});
      end else chk("burst tag", {bb_inning, bb_half, bb_action}, q.pop_front());
    end
    if (!rst && err && !err_allow) begin
      n_vec++;
      n_err++;
      $display("FAIL err: got 1, required 0");
    end
  end

  always @(negedge clk) begin
    if (!rst && bb_in_valid2) begin
      if (q2.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL small burst tag: unexpected beat %0h, required none", {bb_inning2, bb_half2, bb_action2});
      end else chk("small burst tag", {bb_inning2, bb_half2, bb_action2}, q2.pop_front());
    end
  end

  task automatic send(input bit sel, input int a, input int l, input int inn, input int h, input bit push);
    int t = 0;
    if (sel) begin s_valid2 = 1; s_action2 = 3'(a); s_last2 = 1'(l); end
    else begin s_valid = 1; s_action = 3'(a); s_last = 1'(l); end
    while (!rdy(sel) && t < 20) begin @(posedge clk); #1; t++; end
    if (t == 20) begin
      n_vec++;
      n_err++;
      $display("FAIL send: s_ready never rose, required 1");
    end
    @(posedge clk); #1;
    if (sel) begin s_valid2 = 0; s_last2 = 0; end
    else begin s_valid = 0; s_last = 0; end
    if (push && sel) q2.push_back({2'(inn), 1'(h), 3'(a)});
    if (push && !sel) q.push_back({2'(inn), 1'(h), 3'(a)});
  endtask

  // call right after the closing beat's edge
  task automatic burst(input bit sel, input int n, input string nm, input bit do_done);
    int len = 0;
    @(negedge clk);
    chk({nm, " s_ready drop"}, rdy(sel), 0);
    chk({nm, " valid at +1"}, vld(sel), 0);
    @(negedge clk);
    chk({nm, " valid at +2"}, vld(sel), 1);
    while (vld(sel) && len < n + 4) begin len++; @(negedge clk); end
    chk({nm, " burst len"}, len, n);
    chk({nm, " idle outputs"}, sel ? {bb_inning2, bb_half2, bb_action2} : {bb_inning, bb_half, bb_action}, 0);
    chk({nm, " s_ready in wait"}, rdy(sel), 0);
    s_valid = 0;
    s_valid2 = 0;
    if (do_done) begin
      @(posedge clk); #1;
      if (sel) done_i2 = 1; else done_i = 1;
      @(posedge clk); #1;
      done_i = 0;
      done_i2 = 0;
      @(negedge clk);
      chk({nm, " s_ready after done"}, rdy(sel), 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset s_ready", s_ready, 0);
    chk("reset outputs", {bb_in_valid, bb_inning, bb_half, bb_action, err}, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("s_ready before first edge", s_ready, 0);
    @(negedge clk);
    chk("s_ready after reset", s_ready, 1);

    for (int i = 0; i < 18; i++) send(0, 7, i == 17, i / 6 + 1, (i / 3) % 2, 1);
    burst(0, 18, "full game", 1);

    send(0, 0, 0, 1, 0, 1);
    send(0, 6, 0, 1, 0, 1);
    send(0, 7, 0, 1, 0, 1);
    send(0, 1, 1, 1, 1, 1);
    burst(0, 4, "double play", 1);

    for (int i = 0; i < 18; i++) send(0, 7, 0, i / 6 + 1, (i / 3) % 2, 1);
    s_valid = 1;
    s_action = 1;
    burst(0, 18, "auto close", 1);

    send(0, 1, 0, 1, 0, 1);
    send(0, 4, 0, 1, 0, 1);
    send(0, 2, 1, 1, 0, 1);
    burst(0, 3, "early close", 1);

    for (int i = 0; i < 5; i++) send(1, 1, 0, 1, 0, 0);
    @(negedge clk);
    chk("overflow err", err2, 1);
    chk("overflow stays load", s_ready2, 1);
    chk("overflow no valid", bb_in_valid2, 0);
    @(negedge clk);
    chk("overflow err pulse", err2, 0);
    chk("overflow still no valid", bb_in_valid2, 0);
    send(1, 6, 0, 1, 0, 1);
    send(1, 7, 0, 1, 0, 1);
    send(1, 1, 1, 1, 0, 1);
    burst(1, 3, "after overflow", 1);

    for (int i = 0; i < 5; i++) send(0, 1, i == 4, 1, 0, 1);
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid burst valid", bb_in_valid, 1);
    #1 rst = 1;
    @(negedge clk);
    chk("reset drops valid", bb_in_valid, 0);
    q.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("s_ready held after reset", s_ready, 0);
    @(negedge clk);
    chk("s_ready after mid reset", s_ready, 1);

    send(0, 7, 0, 1, 0, 1);
    send(0, 7, 0, 1, 0, 1);
    send(0, 5, 0, 1, 0, 1);
    send(0, 3, 1, 1, 1, 1);
    burst(0, 4, "after reset", 1);

`ifdef BB_FEEDER_TIMEOUT_EN
    send(0, 0, 1, 1, 0, 1);
    err_allow = 1;
    burst(0, 1, "timeout", 0);
    repeat (7) @(negedge clk);
    chk("timeout err early", err, 0);
    @(negedge clk);
    chk("timeout err", err, 1);
    chk("timeout to load", s_ready, 1);
    @(negedge clk);
    chk("timeout err pulse", err, 0);
    err_allow = 0;
`endif

    chk("scoreboard drained", q.size(), 0);
    chk("small scoreboard drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
